decoder_stage: RTL and testbench

- RV32I instruction-decode pipeline stage that sits between fetch and execute.
- Decodes the instruction into register addresses, funct3, a sign-extended immediate, a one-hot opcode class, a one-hot ALU operation and exception flags.
- Contains the integer register file: two read ports for rs1/rs2 and one write-back port.
- All decode outputs are registered, so the stage is one pipeline register deep.

---
 rtl/decoder_stage.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_decoder_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decoder_stage.sv
// RV32I decode stage: field extraction, immediate, one-hot class/ALU/exception, integer register file.
// Latency: one cycle from an accepted instruction to registered decode outputs.
// Backpressure: stall freezes every registered output; flush drops ce; both also pass straight upstream.
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module decoder_stage #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int DEPTH    = 1 << AWIDTH,
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32
) (
  input  logic                          ds_clk,
  input  logic                          ds_rst,
  input  logic [IWIDTH-1:0]             ds_i_instr,
  input  logic [PC_WIDTH-1:0]           ds_i_pc,
  input  logic                          ds_i_ce,
  input  logic                          ds_i_stall,
  input  logic                          ds_i_flush,
  input  logic [DWIDTH-1:0]             ds_data_in_rd,
  input  logic                          ds_we,
  input  logic                          ds_read_reg,
  output logic [PC_WIDTH-1:0]           ds_o_pc,
  output logic [AWIDTH-1:0]             ds_o_addr_rs1_p,
  output logic [AWIDTH-1:0]             ds_o_addr_rs2_p,
  output logic [AWIDTH-1:0]             ds_o_addr_rd_p,
  output logic [2:0]                    ds_o_funct3,
  output logic [DWIDTH-1:0]             ds_o_imm,
  output logic [`ALU_WIDTH-1:0]         ds_o_alu,
  output logic [`OPCODE_WIDTH-1:0]      ds_o_opcode,
  output logic [`EXCEPTION_WIDTH-1:0]   ds_o_exception,
  output logic                          ds_o_ce,
  output logic                          ds_o_stall,
  output logic                          ds_o_flush,
  output logic [DWIDTH-1:0]             ds_data_out_rs1,
  output logic [DWIDTH-1:0]             ds_data_out_rs2
);

  localparam int AW = `ALU_WIDTH;
  localparam int OW = `OPCODE_WIDTH;
  localparam int EW = `EXCEPTION_WIDTH;

  // ALU one-hot bit positions
  localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4, A_OR = 5, A_AND = 6;
  localparam int A_SLL = 7, A_SRL = 8, A_SRA = 9, A_EQ = 10, A_NEQ = 11, A_GE = 12, A_GEU = 13;

  // Instruction-class one-hot bit positions
  localparam int O_RTYPE = 0, O_ITYPE = 1, O_LOAD = 2, O_STORE = 3, O_BRANCH = 4, O_JAL = 5;
  localparam int O_JALR = 6, O_LUI = 7, O_AUIPC = 8, O_SYSTEM = 9, O_FENCE = 10;

  // Exception bit positions
  localparam int E_ILLEGAL = 0, E_ECALL = 1, E_EBREAK = 2, E_MRET = 3;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  logic [6:0]        opc;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [AWIDTH-1:0] rs1, rs2, rd;
  logic [DWIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc    = ds_i_instr[6:0];
  assign funct3 = ds_i_instr[14:12];
  assign funct7 = ds_i_instr[31:25];
  assign rs1    = ds_i_instr[19:15];
  assign rs2    = ds_i_instr[24:20];
  assign rd     = ds_i_instr[11:7];

  assign imm_i = {{(DWIDTH-12){ds_i_instr[31]}}, ds_i_instr[31:20]};
  assign imm_s = {{(DWIDTH-12){ds_i_instr[31]}}, ds_i_instr[31:25], ds_i_instr[11:7]};
  assign imm_b = {{(DWIDTH-13){ds_i_instr[31]}}, ds_i_instr[31], ds_i_instr[7],
                  ds_i_instr[30:25], ds_i_instr[11:8], 1'b0};
  assign imm_u = {{(DWIDTH-32){ds_i_instr[31]}}, ds_i_instr[31:12], 12'b0};
  assign imm_j = {{(DWIDTH-21){ds_i_instr[31]}}, ds_i_instr[31], ds_i_instr[19:12],
                  ds_i_instr[20], ds_i_instr[30:21], 1'b0};

  assign ds_o_stall = ds_i_stall;
  assign ds_o_flush = ds_i_flush;

  // Arithmetic/logic op shared by R-type and I-type; alt picks SUB (R only) or SRA.
  function automatic logic [AW-1:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                                 input logic allow_sub);
    logic [AW-1:0] a;
    a = '0;
    case (f3)
      3'b000: a[(alt && allow_sub) ? A_SUB : A_ADD] = 1'b1;
      3'b001: a[A_SLL]  = 1'b1;
      3'b010: a[A_SLT]  = 1'b1;
      3'b011: a[A_SLTU] = 1'b1;
      3'b100: a[A_XOR]  = 1'b1;
      3'b101: a[alt ? A_SRA : A_SRL] = 1'b1;
      3'b110: a[A_OR]   = 1'b1;
      default: a[A_AND] = 1'b1;
    endcase
    return a;
  endfunction

  logic [AW-1:0]     dec_alu;
  logic [OW-1:0]     dec_opcode;
  logic [EW-1:0]     dec_exc;
  logic [DWIDTH-1:0] dec_imm;
  logic              illegal;

  // Combinational decode of class, ALU op, immediate and exceptions; illegal encodings clear class/op.
  always_comb begin
    dec_alu    = '0;
    dec_opcode = '0;
    dec_exc    = '0;
    dec_imm    = '0;
    illegal    = 1'b0;
    case (opc)
      OP_RTYPE: begin
        dec_opcode[O_RTYPE] = 1'b1;
        dec_alu = alu_from_f3(funct3, funct7[5], 1'b1);
        // Only 0000000 is legal everywhere; 0100000 only for SUB and SRA.
        if (!(funct7 == 7'b0000000 ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
          illegal = 1'b1;
      end
      OP_ITYPE: begin
        dec_opcode[O_ITYPE] = 1'b1;
        dec_imm = imm_i;
        dec_alu = alu_from_f3(funct3, ds_i_instr[30], 1'b0);
        // Shift-immediates carry a funct7 field that must be a recognised value.
        if (funct3 == 3'b001 && funct7 != 7'b0000000)
          illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
          illegal = 1'b1;
      end
      OP_LOAD: begin
        dec_opcode[O_LOAD] = 1'b1;
        dec_imm = imm_i;
        dec_alu[A_ADD] = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
          illegal = 1'b1;
      end
      OP_STORE: begin
        dec_opcode[O_STORE] = 1'b1;
        dec_imm = imm_s;
        dec_alu[A_ADD] = 1'b1;
        if (funct3[2] || funct3 == 3'b011)
          illegal = 1'b1;
      end
      OP_BRANCH: begin
        dec_opcode[O_BRANCH] = 1'b1;
        dec_imm = imm_b;
        case (funct3)
          3'b000: dec_alu[A_EQ]   = 1'b1;
          3'b001: dec_alu[A_NEQ]  = 1'b1;
          3'b100: dec_alu[A_SLT]  = 1'b1;
          3'b101: dec_alu[A_GE]   = 1'b1;
          3'b110: dec_alu[A_SLTU] = 1'b1;
          3'b111: dec_alu[A_GEU]  = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec_opcode[O_JAL] = 1'b1;
        dec_imm = imm_j;
        dec_alu[A_ADD] = 1'b1;
      end
      OP_JALR: begin
        dec_opcode[O_JALR] = 1'b1;
        dec_imm = imm_i;
        dec_alu[A_ADD] = 1'b1;
        if (funct3 != 3'b000)
          illegal = 1'b1;
      end
      OP_LUI: begin
        dec_opcode[O_LUI] = 1'b1;
        dec_imm = imm_u;
        dec_alu[A_ADD] = 1'b1;
      end
      OP_AUIPC: begin
        dec_opcode[O_AUIPC] = 1'b1;
        dec_imm = imm_u;
        dec_alu[A_ADD] = 1'b1;
      end
      OP_SYSTEM: begin
        dec_opcode[O_SYSTEM] = 1'b1;
        // Only the three privileged encodings are recognised; anything else is illegal.
        if (ds_i_instr[31:0] == INSTR_ECALL)       dec_exc[E_ECALL]  = 1'b1;
        else if (ds_i_instr[31:0] == INSTR_EBREAK) dec_exc[E_EBREAK] = 1'b1;
        else if (ds_i_instr[31:0] == INSTR_MRET)   dec_exc[E_MRET]   = 1'b1;
        else                                       illegal = 1'b1;
      end
      OP_FENCE: begin
        dec_opcode[O_FENCE] = 1'b1;
        if (funct3[2:1] != 2'b00)
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec_opcode = '0;
      dec_alu    = '0;
      dec_imm    = '0;
      dec_exc    = '0;
      dec_exc[E_ILLEGAL] = 1'b1;
    end
  end

  logic [DWIDTH-1:0] regs [DEPTH];
  logic [DWIDTH-1:0] rd_data1, rd_data2;

  // Register file: cleared on reset, x0 never written, write port addressed by instr[11:7].
  always_ff @(posedge ds_clk) begin
    if (ds_rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (ds_we && rd != '0) begin
      regs[rd] <= ds_data_in_rd;
    end
  end

  // Read ports with write-first bypass; x0 is forced to zero.
  always_comb begin
    rd_data1 = regs[rs1];
    rd_data2 = regs[rs2];
    if (ds_we && rd != '0 && rd == rs1) rd_data1 = ds_data_in_rd;
    if (ds_we && rd != '0 && rd == rs2) rd_data2 = ds_data_in_rd;
    if (rs1 == '0) rd_data1 = '0;
    if (rs2 == '0) rd_data2 = '0;
  end

  // Pipeline register: reset > flush > stall > advance; idle cycles only drop ce.
  always_ff @(posedge ds_clk) begin
    if (ds_rst) begin
      ds_o_pc         <= '0;
      ds_o_addr_rs1_p <= '0;
      ds_o_addr_rs2_p <= '0;
      ds_o_addr_rd_p  <= '0;
      ds_o_funct3     <= '0;
      ds_o_imm        <= '0;
      ds_o_alu        <= '0;
      ds_o_opcode     <= '0;
      ds_o_exception  <= '0;
      ds_o_ce         <= 1'b0;
      ds_data_out_rs1 <= '0;
      ds_data_out_rs2 <= '0;
    end else if (ds_i_flush) begin
      ds_o_ce <= 1'b0;
    end else if (ds_i_stall) begin
      ds_o_ce <= ds_o_ce;
    end else if (ds_i_ce) begin
      ds_o_pc         <= ds_i_pc;
      ds_o_addr_rs1_p <= rs1;
      ds_o_addr_rs2_p <= rs2;
      ds_o_addr_rd_p  <= rd;
      ds_o_funct3     <= funct3;
      ds_o_imm        <= dec_imm;
      ds_o_alu        <= dec_alu;
      ds_o_opcode     <= dec_opcode;
      ds_o_exception  <= dec_exc;
      ds_o_ce         <= 1'b1;
      if (ds_read_reg) begin
        ds_data_out_rs1 <= rd_data1;
        ds_data_out_rs2 <= rd_data2;
      end
    end else begin
      ds_o_ce <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_stage.sv
// Directed bench for decoder_stage: reset, decode formats, register file, stall and flush.
// Inputs change #1 after a rising edge and outputs are read there too.
// Each scenario task compares against hand-computed values.
module tb_decoder_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc, data_in;
  logic        ce, stall, flush, we, read_reg;
  logic [31:0] o_pc, o_imm, d1, d2;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [2:0]  o_f3;
  logic [13:0] o_alu;
  logic [10:0] o_opc;
  logic [3:0]  o_exc;
  logic        o_ce, o_stall, o_flush;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  decoder_stage dut (
    .ds_clk(clk), .ds_rst(rst), .ds_i_instr(instr), .ds_i_pc(pc), .ds_i_ce(ce),
    .ds_i_stall(stall), .ds_i_flush(flush), .ds_data_in_rd(data_in), .ds_we(we),
    .ds_read_reg(read_reg), .ds_o_pc(o_pc), .ds_o_addr_rs1_p(o_rs1),
    .ds_o_addr_rs2_p(o_rs2), .ds_o_addr_rd_p(o_rd), .ds_o_funct3(o_f3),
    .ds_o_imm(o_imm), .ds_o_alu(o_alu), .ds_o_opcode(o_opc), .ds_o_exception(o_exc),
    .ds_o_ce(o_ce), .ds_o_stall(o_stall), .ds_o_flush(o_flush),
    .ds_data_out_rs1(d1), .ds_data_out_rs2(d2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] p);
    instr = i; pc = p; ce = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; instr = 32'h003100B3; pc = 32'h10;
    step(); step();
    rst = 1'b0; ce = 1'b0;
    step();
    checks++; if (o_ce !== 1'b0) begin fails++; $display("FAIL reset_ce got %0b want 0", o_ce); end
    checks++; if (o_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", o_pc); end
    checks++; if ({o_imm, o_alu, o_opc, o_exc} !== '0) begin fails++; $display("FAIL reset_dec got %h/%h/%h/%h want 0", o_imm, o_alu, o_opc, o_exc); end
    checks++; if ({o_rs1, o_rs2, o_rd, o_f3} !== '0) begin fails++; $display("FAIL reset_fields got %h want 0", {o_rs1, o_rs2, o_rd, o_f3}); end
    checks++; if ({d1, d2} !== 64'h0) begin fails++; $display("FAIL reset_data got %h %h want 0 0", d1, d2); end
  endtask

  task automatic test_rtype();
    we = 1'b1; data_in = 32'hDEADBEEF; read_reg = 1'b1;
    issue(32'h003100B3, 32'h4);
    step();
    we = 1'b0; ce = 1'b0;
    checks++; if (o_pc !== 32'h4) begin fails++; $display("FAIL add_pc got %h want 4", o_pc); end
    checks++; if ({o_rs1, o_rs2, o_rd, o_f3} !== {5'd2, 5'd3, 5'd1, 3'b000}) begin fails++; $display("FAIL add_fields got %0d %0d %0d %0d want 2 3 1 0", o_rs1, o_rs2, o_rd, o_f3); end
    checks++; if ({d1, d2} !== 64'h0) begin fails++; $display("FAIL add_data got %h %h want 0 0", d1, d2); end
    checks++; if (o_imm !== 32'h0) begin fails++; $display("FAIL add_imm got %h want 0", o_imm); end
    checks++; if (o_opc !== 11'h001 || o_alu !== 14'h0001 || o_exc !== 4'h0) begin fails++; $display("FAIL add_dec got %h %h %h want 001 0001 0", o_opc, o_alu, o_exc); end
    checks++; if (o_ce !== 1'b1) begin fails++; $display("FAIL add_ce got %0b want 1", o_ce); end
  endtask

  task automatic test_itype_regfile();
    we = 1'b0; read_reg = 1'b1;
    issue(32'h00108113, 32'h8);
    checks++; if (d1 !== 32'hDEADBEEF || d2 !== 32'hDEADBEEF) begin fails++; $display("FAIL addi_data got %h %h want deadbeef deadbeef", d1, d2); end
    checks++; if (o_imm !== 32'h1 || o_opc !== 11'h002 || o_alu !== 14'h0001) begin fails++; $display("FAIL addi_dec got %h %h %h want 1 002 0001", o_imm, o_opc, o_alu); end
    we = 1'b1; data_in = 32'h12345678;
    issue(32'h00028293, 32'hC);
    checks++; if (d1 !== 32'h12345678) begin fails++; $display("FAIL bypass_rs1 got %h want 12345678", d1); end
    we = 1'b0;
    issue(32'h00028313, 32'h10);
    checks++; if (d1 !== 32'h12345678) begin fails++; $display("FAIL x5_stored got %h want 12345678", d1); end
    we = 1'b1; data_in = 32'h0000FFFF;
    issue(32'h00000033, 32'h14);
    checks++; if (d1 !== 32'h0 || d2 !== 32'h0) begin fails++; $display("FAIL x0_bypass got %h %h want 0 0", d1, d2); end
    we = 1'b0;
    issue(32'h00000033, 32'h18);
    checks++; if (d1 !== 32'h0) begin fails++; $display("FAIL x0_write got %h want 0", d1); end
    read_reg = 1'b0;
    issue(32'h00028313, 32'h1C);
    checks++; if (d1 !== 32'h0) begin fails++; $display("FAIL read_hold got %h want 0", d1); end
    read_reg = 1'b1;
  endtask

  task automatic test_branch();
    issue(32'hFE000EE3, 32'h20);
    checks++; if (o_imm !== 32'hFFFFFFFC) begin fails++; $display("FAIL beq_imm got %h want fffffffc", o_imm); end
    checks++; if (o_alu !== 14'h0400 || o_opc !== 11'h010 || o_exc !== 4'h0) begin fails++; $display("FAIL beq_dec got %h %h %h want 0400 010 0", o_alu, o_opc, o_exc); end
  endtask

  task automatic test_formats();
    issue(32'h40310133, 32'h24);
    checks++; if (o_alu !== 14'h0002 || o_opc !== 11'h001) begin fails++; $display("FAIL sub_dec got %h %h want 0002 001", o_alu, o_opc); end
    issue(32'h4030D093, 32'h28);
    checks++; if (o_alu !== 14'h0200 || o_opc !== 11'h002 || o_imm !== 32'h403) begin fails++; $display("FAIL srai_dec got %h %h %h want 0200 002 403", o_alu, o_opc, o_imm); end
    issue(32'h0020A423, 32'h2C);
    checks++; if (o_imm !== 32'h8 || o_opc !== 11'h008 || o_alu !== 14'h0001 || o_f3 !== 3'b010) begin fails++; $display("FAIL sw_dec got %h %h %h %h want 8 008 0001 2", o_imm, o_opc, o_alu, o_f3); end
    issue(32'h40314133, 32'h30);
    checks++; if (o_exc !== 4'h1 || o_opc !== 11'h0 || o_alu !== 14'h0) begin fails++; $display("FAIL bad_funct7 got %h %h %h want 1 0 0", o_exc, o_opc, o_alu); end
  endtask

  task automatic test_system_illegal();
    issue(32'h00000073, 32'h34);
    checks++; if (o_exc !== 4'h2 || o_opc !== 11'h200) begin fails++; $display("FAIL ecall got %h %h want 2 200", o_exc, o_opc); end
    issue(32'h00100073, 32'h38);
    checks++; if (o_exc !== 4'h4) begin fails++; $display("FAIL ebreak got %h want 4", o_exc); end
    issue(32'h30200073, 32'h3C);
    checks++; if (o_exc !== 4'h8) begin fails++; $display("FAIL mret got %h want 8", o_exc); end
    issue(32'hFFFFFFFF, 32'h40);
    checks++; if (o_exc !== 4'h1 || o_opc !== 11'h0 || o_alu !== 14'h0) begin fails++; $display("FAIL illegal got %h %h %h want 1 0 0", o_exc, o_opc, o_alu); end
  endtask

  task automatic test_stall_flush();
    issue(32'h123450B7, 32'h44);
    checks++; if (o_imm !== 32'h12345000 || o_opc !== 11'h080 || o_alu !== 14'h0001) begin fails++; $display("FAIL lui_dec got %h %h %h want 12345000 080 0001", o_imm, o_opc, o_alu); end
    stall = 1'b1; instr = 32'hFFFFFFFF; pc = 32'h48; ce = 1'b1;
    #1;
    checks++; if (o_stall !== 1'b1) begin fails++; $display("FAIL stall_out got %0b want 1", o_stall); end
    step();
    checks++; if (o_pc !== 32'h44 || o_imm !== 32'h12345000 || o_opc !== 11'h080 || o_exc !== 4'h0 || o_ce !== 1'b1) begin fails++; $display("FAIL stall_hold got %h %h %h %h %0b want 44 12345000 080 0 1", o_pc, o_imm, o_opc, o_exc, o_ce); end
    flush = 1'b1;
    #1;
    checks++; if (o_flush !== 1'b1) begin fails++; $display("FAIL flush_out got %0b want 1", o_flush); end
    step();
    checks++; if (o_ce !== 1'b0 || o_pc !== 32'h44) begin fails++; $display("FAIL flush_ce got %0b %h want 0 44", o_ce, o_pc); end
    flush = 1'b0; stall = 1'b0; ce = 1'b0;
    #1;
    checks++; if (o_stall !== 1'b0 || o_flush !== 1'b0) begin fails++; $display("FAIL passthru_low got %0b %0b want 0 0", o_stall, o_flush); end
    step();
    checks++; if (o_ce !== 1'b0 || o_pc !== 32'h44 || o_opc !== 11'h080) begin fails++; $display("FAIL idle_hold got %0b %h %h want 0 44 080", o_ce, o_pc, o_opc); end
    issue(32'hFFFFFFFF, 32'h48);
    checks++; if (o_ce !== 1'b1 || o_pc !== 32'h48 || o_exc !== 4'h1) begin fails++; $display("FAIL resume got %0b %h %h want 1 48 1", o_ce, o_pc, o_exc); end
  endtask

  initial begin
    rst = 1'b1; instr = '0; pc = '0; data_in = '0;
    ce = 1'b0; stall = 1'b0; flush = 1'b0; we = 1'b0; read_reg = 1'b0;
    test_reset();
    test_rtype();
    test_itype_regfile();
    test_branch();
    test_formats();
    test_system_illegal();
    test_stall_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
